seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-002 Parameter ON_CYCLES, default 100000, clock cycles each digit is lit per visit (>=1).
REQ-003 Parameter BLANK_CYCLES, default 200, clock cycles all anodes are off between digits (>=0).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst_btn  input  1  synchronous active-low reset.
REQ-006 result_valid  input  1  single-cycle strobe: result carries a new classification.
REQ-007 result  input  4  classification value to display as one hex digit.
REQ-008 clear  input  1  synchronous request to blank all history digits.
REQ-009 anodes  output  4  digit enables, active-low; bit 0 is the rightmost digit.
REQ-010 segments  output  8  {dp, g..a}, active-low; dp is always 1 (off).

Function
REQ-011 The block SHALL keep a 4-entry history of 4-bit results plus one valid bit per entry; entry 0 is the newest.
REQ-012 On result_valid=1, history SHALL shift (entry3<=entry2, entry2<=entry1, entry1<=entry0, entry0<=result), and valid bits SHALL shift the same way with valid0<=1; the oldest entry is discarded.
REQ-013 On clear=1 without result_valid, all valid bits SHALL go 0; stored values may be kept.
REQ-014 On clear=1 and result_valid=1 in the same cycle, valid bits SHALL become 4'b0001 and entry0<=result.
REQ-015 Scan FSM states: BLANK, SHOW; one cycle counter and a 2-bit digit index idx.
REQ-016 BLANK SHALL last exactly BLANK_CYCLES cycles, then go to SHOW with counter 0; if BLANK_CYCLES=0, BLANK SHALL be skipped and SHOW SHALL advance directly to the next digit.
REQ-017 SHOW SHALL last exactly ON_CYCLES cycles, then go to BLANK with idx<=idx+1, wrapping 3->0.
REQ-018 The full scan period SHALL be exactly 4*(ON_CYCLES+BLANK_CYCLES) cycles, with digit order 0,1,2,3,0...
REQ-019 anodes and segments SHALL be registered; they reflect FSM state and history one cycle after that state.
REQ-020 In SHOW: anodes SHALL be ~(1<<idx); segments SHALL be {1'b1, hex pattern of entry[idx]} if valid[idx]=1, else 8'hFF.
REQ-021 In BLANK: anodes SHALL be 4'b1111 and segments SHALL be 8'hFF.
REQ-022 A history update during SHOW SHALL appear on the lit digit on the cycle after the update; the scan timing SHALL NOT be disturbed.
REQ-023 At no cycle SHALL more than one anode bit be 0.

Reset
REQ-024 With rst_btn=0 on a clock edge: state<=BLANK, counter<=0, idx<=0, all valid bits<=0, anodes<=4'b1111, segments<=8'hFF.
REQ-025 Reset asserted mid-SHOW SHALL blank outputs on the next edge and clear the history; result_valid during reset SHALL be ignored.

Structure
REQ-026 Shared package seg_pkg SHALL hold the scan-state enum, NUM_DIGITS=4, and the blank segment constant 8'hFF.
REQ-027 Segment decoding SHALL use the existing combinational hex_disp sub-module (one instance, muxed by idx); no other sub-modules.

Verification (ON_CYCLES=4, BLANK_CYCLES=1)
REQ-028 Reset release, no results -> anodes cycle through 1110,1111,1101,1111,1011,1111,0111,1111 with a 4/1 cycle split, segments 8'hFF throughout, period 20 cycles.
REQ-029 Strobe results 1,2,3,4,5 -> digits 0..3 show 5,4,3,2 (segments 0x92, 0x99, 0xB0, 0xA4); value 1 is discarded.
REQ-030 Single result A -> digit 0 shows 0x88 while lit; digits 1..3 stay 8'hFF while their anodes are low.
REQ-031 clear and result_valid with 7 in the same cycle -> only digit 0 is lit (0xF8); others blank.
REQ-032 result_valid with 0 while digit 0 is lit -> segments change to 0xC0 on the next cycle; anode timing unchanged.
REQ-033 rst_btn low for 1 cycle mid-SHOW -> next cycle anodes 1111, segments FF; history empty after release.

Source files
------------

// File: rtl/seg_pkg.sv
//------------------------------------------------------------------------------
// seg_pkg : shared types and constants for the seven-segment scan controller
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

package seg_pkg;

    localparam int          NUM_DIGITS = 4;
    localparam logic [7:0]  SEG_BLANK  = 8'hFF;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/hex_disp.sv
//------------------------------------------------------------------------------
// hex_disp : combinational hex digit to active-low {g..a} segment decoder
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module hex_disp (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (digit)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
//------------------------------------------------------------------------------
// seg_scan_ctrl : 4-digit result history shown on a multiplexed 7-seg display
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int ON_CYCLES    = 100000,
    parameter int BLANK_CYCLES = 200
) (
    input  logic       clk,
    input  logic       rst_btn,
    input  logic       result_valid,
    input  logic [3:0] result,
    input  logic       clear,
    output logic [3:0] anodes,
    output logic [7:0] segments
);

    localparam int MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    logic [3:0]  r_entry [NUM_DIGITS];
    logic [3:0]  r_valid;
    scan_state_t r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]  r_idx, w_idx_nxt;
    logic [3:0]  w_an_nxt;
    logic [7:0]  w_seg_nxt;
    logic [6:0]  w_hex;

    // A simultaneous clear keeps only the incoming result visible.
    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            r_valid <= 4'b0000;
            for (int i = 0; i < NUM_DIGITS; i++) r_entry[i] <= 4'h0;
        end else if (result_valid) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) r_entry[i] <= r_entry[i-1];
            r_entry[0] <= result;
            r_valid    <= clear ? 4'b0001 : {r_valid[2:0], 1'b1};
        end else if (clear) begin
            r_valid <= 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_BLANK: begin
                if (BLANK_CYCLES == 0 || r_cnt == BLANK_LAST) begin
                    w_state_nxt = ST_SHOW;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SHOW: begin
                if (r_cnt == ON_LAST) begin
                    w_state_nxt = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = r_idx + 2'd1;
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    hex_disp u_hex (
        .digit (r_entry[r_idx]),
        .seg   (w_hex)
    );

    always_comb begin
        w_an_nxt  = 4'b1111;
        w_seg_nxt = SEG_BLANK;
        if (r_state == ST_SHOW) begin
            w_an_nxt  = ~(4'b0001 << r_idx);
            w_seg_nxt = r_valid[r_idx] ? {1'b1, w_hex} : SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            anodes   <= 4'b1111;
            segments <= SEG_BLANK;
        end else begin
            anodes   <= w_an_nxt;
            segments <= w_seg_nxt;
        end
    end

endmodule

`default_nettype wire
